// File: rtl/ram_arbiter.sv
// ram_arbiter: shares a single-port data RAM (synchronous write, combinational
// read) between the processor core (port 0) and a second bus master (port 1).
//
// Each port uses a REQ/ACK handshake. The winning request's WE/ADDR/WDATA are
// latched at grant, the RAM is driven for exactly one cycle, read data is
// captured at the end of that cycle and ACK pulses for one cycle. Contention
// is resolved round-robin (FIXED_PRI=0) or always in favour of port 0
// (FIXED_PRI=1).
//
// Parameters:
//   DATA_WIDTH  RAM word width
//   ADDR_WIDTH  RAM address width (full RAM range, no range check)
//   FIXED_PRI   1 = port 0 wins contention, 0 = round-robin
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   req0/1               access request, held until the matching ack
//   we0/1, addr0/1,
//   wdata0/1             access descriptor, sampled at grant
//   gnt0/1               high for the cycle the port owns the RAM
//   ack0/1               one-cycle completion pulse
//   rdata0/1             read data captured at the end of that port's read
//   ram_ce               RAM write enable
//   ram_addr, ram_din    RAM address / write data (hold outside an access)
//   ram_dout             RAM combinational read data

module ram_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter bit          FIXED_PRI  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  ack0,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  ram_ce,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;

    // Latched write flag of the access in flight; address and write data are
    // latched directly into ram_addr / ram_din, which hold between accesses.
    logic                  we_lat;
    logic                  we_lat_nxt;

    // Last-served port (0 or 1); reset to 1 so port 0 wins the first tie.
    logic                  last;
    logic                  last_nxt;

    logic                  gnt0_nxt;
    logic                  gnt1_nxt;
    logic                  ack0_nxt;
    logic                  ack1_nxt;
    logic                  ram_ce_nxt;
    logic [ADDR_WIDTH-1:0] ram_addr_nxt;
    logic [DATA_WIDTH-1:0] ram_din_nxt;
    logic [DATA_WIDTH-1:0] rdata0_nxt;
    logic [DATA_WIDTH-1:0] rdata1_nxt;

    logic                  elig0;
    logic                  elig1;
    logic                  any_elig;
    logic                  sel1;

    // A port is not eligible while its ack is high, so a REQ still held
    // for the access just completed is not served a second time.
    assign elig0    = req0 & ~ack0;
    assign elig1    = req1 & ~ack1;
    assign any_elig = elig0 | elig1;

    // Winner selection: port 1 wins when alone, or on a tie under
    // round-robin when port 0 was served last.
    always_comb begin
        sel1 = 1'b0;
        if (elig1 && !elig0) begin
            sel1 = 1'b1;
        end else if (elig1 && elig0) begin
            sel1 = !FIXED_PRI && (last == 1'b0);
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (any_elig) begin
                    state_nxt = sel1 ? BUSY1 : BUSY0;
                end
            end
            BUSY0:   state_nxt = IDLE;
            BUSY1:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: next values of every registered output and held field.
    // RAM controls are loaded at grant so they come straight from flops
    // during BUSY and have no combinational path from the request inputs.
    always_comb begin
        gnt0_nxt     = 1'b0;
        gnt1_nxt     = 1'b0;
        ack0_nxt     = 1'b0;
        ack1_nxt     = 1'b0;
        ram_ce_nxt   = 1'b0;
        ram_addr_nxt = ram_addr;
        ram_din_nxt  = ram_din;
        we_lat_nxt   = we_lat;
        last_nxt     = last;
        rdata0_nxt   = rdata0;
        rdata1_nxt   = rdata1;
        case (state)
            IDLE: begin
                if (any_elig) begin
                    if (sel1) begin
                        gnt1_nxt     = 1'b1;
                        ram_ce_nxt   = we1;
                        ram_addr_nxt = addr1;
                        ram_din_nxt  = wdata1;
                        we_lat_nxt   = we1;
                        last_nxt     = 1'b1;
                    end else begin
                        gnt0_nxt     = 1'b1;
                        ram_ce_nxt   = we0;
                        ram_addr_nxt = addr0;
                        ram_din_nxt  = wdata0;
                        we_lat_nxt   = we0;
                        last_nxt     = 1'b0;
                    end
                end
            end
            BUSY0: begin
                ack0_nxt = 1'b1;
                if (!we_lat) begin
                    rdata0_nxt = ram_dout;
                end
            end
            BUSY1: begin
                ack1_nxt = 1'b1;
                if (!we_lat) begin
                    rdata1_nxt = ram_dout;
                end
            end
            default: begin
            end
        endcase
    end

    // Output and held-field registers. Asynchronous reset drops ram_ce and
    // the grants at once, so an access interrupted by reset never writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            ram_ce   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            we_lat   <= 1'b0;
            last     <= 1'b1;
            rdata0   <= '0;
            rdata1   <= '0;
        end else begin
            gnt0     <= gnt0_nxt;
            gnt1     <= gnt1_nxt;
            ack0     <= ack0_nxt;
            ack1     <= ack1_nxt;
            ram_ce   <= ram_ce_nxt;
            ram_addr <= ram_addr_nxt;
            ram_din  <= ram_din_nxt;
            we_lat   <= we_lat_nxt;
            last     <= last_nxt;
            rdata0   <= rdata0_nxt;
            rdata1   <= rdata1_nxt;
        end
    end

endmodule
